alu_4_stream: RTL and testbench
===============================

// Module: alu_4_stream
// PURPOSE
//  Streaming front/back end for the combinational alu_4 datapath. Accepts
//  {A,B,CTRL} commands over a valid/ready handshake and registers them into an
//  issue stage that drives alu_4. Results are buffered in a 2-entry FIFO and
//  returned over a valid/ready handshake, with zero/illegal flags and
//  saturating statistics. Sits between the command source and the result sink.
// PARAMETERS
//  CNT_W    16   width of the saturating op_count / illegal_count counters
//  FIFO_D   2    result FIFO depth (power of 2, >=2)
// PORTS
//  clk            in   1      single clock, all state on rising edge
//  rst_n          in   1      asynchronous active-low reset
//  in_valid       in   1      command valid
//  in_ready       out  1      block can accept a command this cycle
//  in_a           in   4      operand A
//  in_b           in   4      operand B
//  in_ctrl        in   4      opcode, same encoding as alu_4 CTRL
//  out_valid      out  1      result FIFO head valid
//  out_ready      in   1      sink accepts head this cycle
//  out_y          out  8      alu_4 Y of the head command
//  out_ctrl       out  4      opcode echoed with the result
//  out_zero       out  1      out_y == 8'h00
//  out_illegal    out  1      opcode in 4'b1010..4'b1111
//  stat_clr       in   1      synchronous clear of both counters
//  op_count       out  CNT_W  results popped, saturating at all-ones
//  illegal_count  out  CNT_W  illegal results popped, saturating
// BEHAVIOUR
//  Reset (rst_n=0, async): issue stage empty, FIFO empty, all counters 0.
//   in_ready=1, out_valid=0, and out_y/out_ctrl/out_zero/out_illegal=0.
//  Opcodes 0000 A+B, 0001 A-B, 0010..1000 logic ops per alu_4, 1001 A*B.
//   Opcodes 1010..1111 are legal to accept: alu_4 returns Y=0, out_illegal=1.
//  Accept: in_valid&&in_ready at edge N loads the issue register (s1_valid=1).
//  Push: s1_valid && (!fifo_full || pop) at edge N+1 writes {Y,ctrl,zero,ill}.
//   Y is taken from alu_4 combinationally; out_valid is seen after edge N+1.
//   Minimum latency is 2 edges; throughput is 1 per cycle when out_ready=1.
//  in_ready = !s1_valid || push; it is combinational from out_ready through
//   fifo_full, so a full FIFO with a simultaneous pop still accepts.
//  Pop: out_valid && out_ready. Output fields are the FIFO head and are held
//   stable while out_valid && !out_ready.
//  Simultaneous push and pop on a full FIFO: both occur and occupancy is
//   unchanged. Push and pop on an empty FIFO: no bypass; the push is stored.
//  Occupancy cannot exceed FIFO_D. Read/write pointers wrap mod FIFO_D.
//  Counters: on pop, op_count+1, and illegal_count+1 if the head is illegal.
//   Both saturate at all-ones. stat_clr has priority over a same-cycle
//   increment.
//  Reset mid-operation discards the issue stage and FIFO contents with no
//   flush handshake. in_valid is ignored while rst_n=0.
// STRUCTURE
//  alu_4_pkg: localparams OP_ADD..OP_MUL and OP_ILL_MIN=4'b1010; packed struct
//   res_t {y[7:0], ctrl[3:0], zero, illegal}.
//  Sub-modules: alu_4 instantiated unchanged; alu_4_res_fifo (res_t, depth
//   FIFO_D, full/empty outputs).
// TESTING
//  1 Reset, then A=3 B=5 CTRL=0000, out_ready=1 -> after 2 edges out_y=8'h08,
//    zero=0, op_count=1.
//  2 A=15 B=15 CTRL=1001 -> out_y=8'hE1. A=0 B=7 CTRL=1001 -> out_y=0, zero=1.
//  3 CTRL=1111, A=9, B=6 -> out_y=8'h00, out_illegal=1, illegal_count=1.
//  4 out_ready=0 with 4 back-to-back commands -> 3 accepted (2 FIFO + issue),
//    in_ready=0. Release out_ready -> all 3 results in order, no loss.
//  5 Full FIFO, out_ready=1 and in_valid=1 in the same cycle -> pop and push
//    together, occupancy stays 2, in_ready=1.
//  6 Assert rst_n=0 with 2 results pending -> out_valid=0 immediately.
//    CNT_W=2: 5 pops -> op_count=3. stat_clr with a pop -> op_count=0.

Source files
------------

// File: rtl/alu_4_pkg.sv
// alu_4_pkg: opcode constants and the result record shared by the alu_4 stream block.
package alu_4_pkg;
    localparam logic [3:0] OP_ADD     = 4'b0000;
    localparam logic [3:0] OP_SUB     = 4'b0001;
    localparam logic [3:0] OP_AND     = 4'b0010;
    localparam logic [3:0] OP_OR      = 4'b0011;
    localparam logic [3:0] OP_XOR     = 4'b0100;
    localparam logic [3:0] OP_NOT     = 4'b0101;
    localparam logic [3:0] OP_NAND    = 4'b0110;
    localparam logic [3:0] OP_NOR     = 4'b0111;
    localparam logic [3:0] OP_XNOR    = 4'b1000;
    localparam logic [3:0] OP_MUL     = 4'b1001;
    localparam logic [3:0] OP_ILL_MIN = 4'b1010;

    typedef struct packed {
        logic [7:0] y;
        logic [3:0] ctrl;
        logic       zero;
        logic       illegal;
    } res_t;
endpackage

// File: rtl/alu_4.sv
// alu_4: combinational 4-bit ALU with an 8-bit result; reserved opcodes yield 0.
module alu_4
    import alu_4_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] ctrl,
    output logic [7:0] y
);
    logic [7:0] a8, b8;
    assign a8 = {4'b0000, a};
    assign b8 = {4'b0000, b};
    always_comb begin
        y = 8'h00;
        case (ctrl)
            OP_ADD:  y = a8 + b8;
            OP_SUB:  y = a8 - b8;
            OP_AND:  y = a8 & b8;
            OP_OR:   y = a8 | b8;
            OP_XOR:  y = a8 ^ b8;
            OP_NOT:  y = {4'b0000, ~a};
            OP_NAND: y = {4'b0000, ~(a & b)};
            OP_NOR:  y = {4'b0000, ~(a | b)};
            OP_XNOR: y = {4'b0000, ~(a ^ b)};
            OP_MUL:  y = a8 * b8;
            default: y = 8'h00;
        endcase
    end
endmodule

// File: rtl/alu_4_res_fifo.sv
// alu_4_res_fifo: power-of-two depth result FIFO; caller never pushes when full without a pop.
module alu_4_res_fifo
    import alu_4_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic pop,
    input  res_t din,
    output res_t dout,
    output logic full,
    output logic empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    res_t mem_q [DEPTH];
    res_t mem_d [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (push) begin
            mem_d[wr_q] = din;
            wr_d        = wr_q + AW'(1);
        end
        if (pop) rd_d = rd_q + AW'(1);
        cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end
    assign dout  = mem_q[rd_q];
    assign full  = cnt_q == CW'(DEPTH);
    assign empty = cnt_q == '0;
endmodule

// File: rtl/alu_4_stream.sv
// alu_4_stream: valid/ready wrapper around alu_4 with an issue register,
// a result FIFO and saturating pop statistics.
module alu_4_stream
    import alu_4_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int FIFO_D = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_a,
    input  logic [3:0]       in_b,
    input  logic [3:0]       in_ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_y,
    output logic [3:0]       out_ctrl,
    output logic             out_zero,
    output logic             out_illegal,
    input  logic             stat_clr,
    output logic [CNT_W-1:0] op_count,
    output logic [CNT_W-1:0] illegal_count
);
    logic             s1_valid_q, s1_valid_d;
    logic [3:0]       s1_a_q, s1_a_d, s1_b_q, s1_b_d, s1_ctrl_q, s1_ctrl_d;
    logic [CNT_W-1:0] op_cnt_q, op_cnt_d, ill_cnt_q, ill_cnt_d;
    logic [7:0]       alu_y;
    logic             full, empty, push, pop, accept;
    res_t             res, head;

    alu_4 u_alu (.a(s1_a_q), .b(s1_b_q), .ctrl(s1_ctrl_q), .y(alu_y));

    alu_4_res_fifo #(.DEPTH(FIFO_D)) u_fifo (
        .clk(clk), .rst_n(rst_n), .push(push), .pop(pop),
        .din(res), .dout(head), .full(full), .empty(empty)
    );

    // A pop frees a slot in the same cycle, so a full FIFO still drains the issue stage.
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    assign push      = s1_valid_q && (!full || pop);
    assign in_ready  = !s1_valid_q || push;
    assign accept    = in_valid && in_ready;
    assign res       = '{y: alu_y, ctrl: s1_ctrl_q, zero: alu_y == 8'h00, illegal: s1_ctrl_q >= OP_ILL_MIN};

    always_comb begin
        s1_valid_d = accept ? 1'b1 : (push ? 1'b0 : s1_valid_q);
        s1_a_d     = accept ? in_a : s1_a_q;
        s1_b_d     = accept ? in_b : s1_b_q;
        s1_ctrl_d  = accept ? in_ctrl : s1_ctrl_q;
        op_cnt_d   = stat_clr ? '0 : (pop && !(&op_cnt_q)) ? op_cnt_q + CNT_W'(1) : op_cnt_q;
        ill_cnt_d  = stat_clr ? '0 : (pop && head.illegal && !(&ill_cnt_q)) ? ill_cnt_q + CNT_W'(1) : ill_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_ctrl_q  <= '0;
            op_cnt_q   <= '0;
            ill_cnt_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_ctrl_q  <= s1_ctrl_d;
            op_cnt_q   <= op_cnt_d;
            ill_cnt_q  <= ill_cnt_d;
        end
    end

    assign out_y         = head.y;
    assign out_ctrl      = head.ctrl;
    assign out_zero      = head.zero;
    assign out_illegal   = head.illegal;
    assign op_count      = op_cnt_q;
    assign illegal_count = ill_cnt_q;
endmodule

// File: tb/tb_alu_4_stream.sv
// tb_alu_4_stream: directed checks of alu_4_stream; a second instance with CNT_W=2 covers saturation.
module tb_alu_4_stream;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, stat_clr;
    logic [3:0]  in_a, in_b, in_ctrl, out_ctrl;
    logic [7:0]  out_y;
    logic        out_zero, out_illegal;
    logic [15:0] op_count, illegal_count;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_stat_clr;
    logic [3:0]  b_in_a, b_in_b, b_in_ctrl, b_out_ctrl;
    logic [7:0]  b_out_y;
    logic        b_out_zero, b_out_illegal;
    logic [1:0]  b_op_count, b_illegal_count;

    int tests = 0;
    int fails = 0;
    int acc;

    always #5 clk = ~clk;

    alu_4_stream #(.CNT_W(16), .FIFO_D(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_ctrl(in_ctrl), .out_valid(out_valid),
        .out_ready(out_ready), .out_y(out_y), .out_ctrl(out_ctrl), .out_zero(out_zero),
        .out_illegal(out_illegal), .stat_clr(stat_clr), .op_count(op_count),
        .illegal_count(illegal_count)
    );

    alu_4_stream #(.CNT_W(2), .FIFO_D(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_a(b_in_a), .in_b(b_in_b), .in_ctrl(b_in_ctrl), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_y(b_out_y), .out_ctrl(b_out_ctrl), .out_zero(b_out_zero),
        .out_illegal(b_out_illegal), .stat_clr(b_stat_clr), .op_count(b_op_count),
        .illegal_count(b_illegal_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_one(input string tag, input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                            input logic [7:0] ey, input logic ez, input logic ei);
        in_valid = 1'b1; in_a = a; in_b = b; in_ctrl = c; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check({tag, "_early"}, out_valid, 1'b0);
        tick();
        check({tag, "_valid"}, out_valid, 1'b1);
        check({tag, "_y"}, out_y, ey);
        check({tag, "_ctrl"}, out_ctrl, c);
        check({tag, "_zero"}, out_zero, ez);
        check({tag, "_ill"}, out_illegal, ei);
        tick();
        check({tag, "_drained"}, out_valid, 1'b0);
    endtask

    task automatic fill(input int n, input logic [3:0] base);
        acc = 0;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1; in_a = base + 4'(i); in_b = 4'd0; in_ctrl = 4'b0000;
            #1;
            acc += int'(in_ready);
            tick();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_ctrl = '0;
        out_ready = 1'b0; stat_clr = 1'b0;
        b_in_valid = 1'b0; b_in_a = '0; b_in_b = '0; b_in_ctrl = '0;
        b_out_ready = 1'b0; b_stat_clr = 1'b0;
        #2;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_y", out_y, 8'h00);
        check("rst_out_ctrl", out_ctrl, 4'h0);
        check("rst_flags", {out_zero, out_illegal}, 2'b00);
        check("rst_op_count", op_count, 16'd0);
        #1 rst_n = 1'b1;

        send_one("add", 4'd3, 4'd5, 4'b0000, 8'h08, 1'b0, 1'b0);
        check("add_op_count", op_count, 16'd1);
        send_one("mul_ff", 4'd15, 4'd15, 4'b1001, 8'hE1, 1'b0, 1'b0);
        send_one("mul_0", 4'd0, 4'd7, 4'b1001, 8'h00, 1'b1, 1'b0);
        send_one("sub", 4'd3, 4'd5, 4'b0001, 8'hFE, 1'b0, 1'b0);
        send_one("and", 4'd12, 4'd10, 4'b0010, 8'h08, 1'b0, 1'b0);
        send_one("ill", 4'd9, 4'd6, 4'b1111, 8'h00, 1'b1, 1'b1);
        check("ill_count", illegal_count, 16'd1);
        check("op_count6", op_count, 16'd6);

        out_ready = 1'b0;
        fill(4, 4'd2);
        check("bp_accepted", acc, 3);
        check("bp_in_ready", in_ready, 1'b0);
        check("bp_head", out_y, 8'h02);
        tick();
        check("bp_hold", out_y, 8'h02);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("bp_valid%0d", k), out_valid, 1'b1);
            check($sformatf("bp_y%0d", k), out_y, 8'(k + 2));
            tick();
        end
        check("bp_empty", out_valid, 1'b0);
        check("bp_op_count", op_count, 16'd9);

        out_ready = 1'b0;
        fill(3, 4'd4);
        check("full_in_ready0", in_ready, 1'b0);
        out_ready = 1'b1; in_valid = 1'b1; in_a = 4'd7; in_b = 4'd0; in_ctrl = 4'b0000;
        #1;
        check("full_pop_in_ready", in_ready, 1'b1);
        tick();
        out_ready = 1'b0; in_valid = 1'b0;
        check("full_head", out_y, 8'h05);
        tick();
        check("full_occ2", in_ready, 1'b0);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("full_y%0d", k), out_y, 8'(k + 5));
            tick();
        end
        check("full_empty", out_valid, 1'b0);

        out_ready = 1'b0;
        fill(2, 4'd1);
        tick();
        check("pend_valid", out_valid, 1'b1);
        #2 rst_n = 1'b0; in_valid = 1'b1;
        #1;
        check("arst_out_valid", out_valid, 1'b0);
        check("arst_out_y", out_y, 8'h00);
        check("arst_in_ready", in_ready, 1'b1);
        tick();
        check("arst_ignore_in", out_valid, 1'b0);
        in_valid = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        tick();
        check("arst_after", out_valid, 1'b0);
        check("arst_op_count", op_count, 16'd0);

        b_out_ready = 1'b1; b_in_valid = 1'b1; b_in_ctrl = 4'b1010; b_in_a = 4'd1;
        for (int i = 0; i < 5; i++) tick();
        b_in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("sat_op_count", b_op_count, 2'd3);
        check("sat_ill_count", b_illegal_count, 2'd3);
        check("sat_empty", b_out_valid, 1'b0);
        b_in_valid = 1'b1; b_in_ctrl = 4'b0000;
        tick();
        b_in_valid = 1'b0;
        tick();
        check("clr_valid", b_out_valid, 1'b1);
        b_stat_clr = 1'b1;
        tick();
        b_stat_clr = 1'b0;
        check("clr_op_count", b_op_count, 2'd0);
        check("clr_ill_count", b_illegal_count, 2'd0);
        check("clr_popped", b_out_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
